// File: rtl/fft_frame_loader.sv
`timescale 1ns/1ps
// fft_frame_loader: captures an audio stream into two ping-pong frame banks and streams
// each full frame into the FFT load port. Optional macro SAMPLE_DECIM_EN: 2:1 pair averaging.
module fft_frame_loader #(
  parameter int BIT_WIDTH = 16,
  parameter int N         = 9,
  parameter int FFT_SIZE  = 512
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid,
  input  logic [BIT_WIDTH-1:0] s_data,
  input  logic                 fft_done,
  input  logic                 clr_overrun,
  output logic                 fft_load,
  output logic                 fft_start,
  output logic [N-1:0]         add_rd,
  output logic [BIT_WIDTH-1:0] din,
  output logic [1:0]           frame_pending,
  output logic                 overrun,
  output logic [1:0]           state_dbg
);

  // Handshake: s_valid is a one-cycle strobe with no backpressure. A sample is taken
  // when the current write bank is not full, otherwise it is dropped and overrun is set.
  // On the FFT side fft_load marks each valid add_rd/din cycle; fft_done only acts in WAIT.

  localparam logic [N-1:0] LAST = N'(FFT_SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREFETCH = 2'd1,
    S_LOAD     = 2'd2,
    S_WAIT     = 2'd3
  } state_t;

  state_t               state;
  logic [BIT_WIDTH-1:0] mem [0:2*FFT_SIZE-1];
  logic [BIT_WIDTH-1:0] rd_q;
  logic [N:0]           rd_addr;
  logic [1:0]           full;
  logic                 wr_bank;
  logic [N-1:0]         wr_addr;
  logic                 rd_bank;
  logic                 rd_next;
  logic [N-1:0]         rd_ptr;
  logic                 accept;
  logic                 drop;
  logic                 wr_en;
  logic [BIT_WIDTH-1:0] wr_data;
  logic                 last_wr;
  logic                 release_en;
  logic                 other_free;
  logic                 start_sel;

  assign accept = s_valid && !full[wr_bank];
  assign drop   = s_valid && full[wr_bank];

`ifdef SAMPLE_DECIM_EN
  logic                 pair_phase;
  logic [BIT_WIDTH-1:0] pair_hold;
  logic [BIT_WIDTH:0]   pair_sum;

  assign pair_sum = {pair_hold[BIT_WIDTH-1], pair_hold} + {s_data[BIT_WIDTH-1], s_data};
  assign wr_en    = accept && pair_phase;
  assign wr_data  = pair_sum[BIT_WIDTH:1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pair_phase <= 1'b0;
      pair_hold  <= '0;
    end else if (drop) begin
      pair_phase <= 1'b0;
    end else if (accept) begin
      if (!pair_phase) pair_hold <= s_data;
      pair_phase <= !pair_phase;
    end
  end
`else
  assign wr_en   = accept;
  assign wr_data = s_data;
`endif

  assign last_wr    = wr_en && (wr_addr == LAST);
  assign release_en = (state == S_LOAD) && (add_rd == LAST);
  assign other_free = !full[!wr_bank] || (release_en && (rd_bank != wr_bank));

  // WAIT with fft_done does IDLE's selection in the same cycle, saving a clock per frame.
  assign start_sel = full[rd_next] && ((state == S_IDLE) || ((state == S_WAIT) && fft_done));

  assign rd_addr   = ((state == S_IDLE) || (state == S_WAIT)) ? {rd_next, {N{1'b0}}}
                                                              : {rd_bank, rd_ptr};
  assign fft_start = fft_load;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_bank, wr_addr}] <= wr_data;
    rd_q <= mem[rd_addr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_bank       <= 1'b0;
      wr_addr       <= '0;
      full          <= '0;
      frame_pending <= '0;
      overrun       <= 1'b0;
    end else begin
      if (wr_en) wr_addr <= last_wr ? '0 : wr_addr + 1'b1;
      // Switch banks on completion, or resume a stalled writer once the other bank frees.
      if ((last_wr || full[wr_bank]) && other_free) wr_bank <= !wr_bank;
      if (release_en) full[rd_bank] <= 1'b0;
      if (last_wr)    full[wr_bank] <= 1'b1;
      frame_pending <= frame_pending + 2'(last_wr) - 2'(release_en);
      if (drop)             overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      rd_bank  <= 1'b0;
      rd_next  <= 1'b0;
      rd_ptr   <= '0;
      fft_load <= 1'b0;
      add_rd   <= '0;
      din      <= '0;
    end else if (start_sel) begin
      state   <= S_PREFETCH;
      rd_bank <= rd_next;
      rd_next <= !rd_next;
      rd_ptr  <= N'(1);
    end else begin
      case (state)
        S_PREFETCH: begin
          state    <= S_LOAD;
          rd_ptr   <= rd_ptr + 1'b1;
          fft_load <= 1'b1;
          add_rd   <= '0;
          din      <= rd_q;
        end
        S_LOAD: begin
          rd_ptr <= rd_ptr + 1'b1;
          if (add_rd == LAST) begin
            fft_load <= 1'b0;
            state    <= S_WAIT;
          end else begin
            add_rd <= add_rd + 1'b1;
            din    <= rd_q;
          end
        end
        S_WAIT: begin
          if (fft_done) state <= S_IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_loader.sv
`timescale 1ns/1ps
// tb_fft_frame_loader: directed frames into fft_frame_loader; expected {add_rd, din}
// pairs are queued as samples are fed and popped by a monitor on every load cycle.
module tb_fft_frame_loader;
  localparam int W  = 16;
  localparam int N  = 9;
  localparam int FS = 512;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd3;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         s_valid = 1'b0;
  logic [W-1:0] s_data = '0;
  logic         fft_done = 1'b0;
  logic         clr_overrun = 1'b0;
  logic         fft_load;
  logic         fft_start;
  logic [N-1:0] add_rd;
  logic [W-1:0] din;
  logic [1:0]   frame_pending;
  logic         overrun;
  logic [1:0]   state_dbg;

  always #5 clk = ~clk;

  fft_frame_loader #(.BIT_WIDTH(W), .N(N), .FFT_SIZE(FS)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data),
    .fft_done(fft_done), .clr_overrun(clr_overrun),
    .fft_load(fft_load), .fft_start(fft_start), .add_rd(add_rd), .din(din),
    .frame_pending(frame_pending), .overrun(overrun), .state_dbg(state_dbg)
  );

  int             n_cmp = 0;
  int             n_fail = 0;
  logic [N+W-1:0] exp_q[$];
  logic [N+W-1:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every load cycle must match the head of the expected queue.
  always @(negedge clk) begin
    if (reset && fft_load) begin
      check("fft_start_eq_load", 32'(fft_start), 32'd1);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_unexpected_load: add_rd=0x%0h din=0x%0h, expected no load", add_rd, din);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_add_rd", 32'(add_rd), 32'(mon_e[N+W-1:W]));
        check("sb_din", 32'(din), 32'(mon_e[W-1:0]));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [W-1:0] v);
    s_data  = v;
    s_valid = 1'b1;
    tick(1);
    s_valid = 1'b0;
  endtask

  task automatic feed_frame(input logic [W-1:0] base);
    for (int i = 0; i < FS; i++) begin
      exp_q.push_back({N'(i), base + W'(i)});
      send(base + W'(i));
    end
  endtask

  task automatic pulse_done;
    fft_done = 1'b1;
    tick(1);
    fft_done = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      s_data  = 16'hA5A5;
      s_valid = (i % 2 == 0);
      tick(1);
    end
    s_valid = 1'b0;
    check("rst_fft_load", 32'(fft_load), 32'd0);
    check("rst_fft_start", 32'(fft_start), 32'd0);
    check("rst_add_rd", 32'(add_rd), 32'd0);
    check("rst_din", 32'(din), 32'd0);
    check("rst_pending", 32'(frame_pending), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    reset = 1'b1;
    tick(2);
    check("rst_no_writes", 32'(frame_pending), 32'd0);
  endtask

  task automatic wait_load(input string name, input int exp_lat);
    int lat = 0;
    while (!fft_load && lat < 20) begin
      tick(1);
      lat++;
    end
    check(name, 32'(lat), 32'(exp_lat));
  endtask

  task automatic burst(input string name, input int done_at);
    int len = 0;
    while (fft_load && len < FS + 8) begin
      fft_done = (len == done_at);
      tick(1);
      len++;
    end
    fft_done = 1'b0;
    check(name, 32'(len), 32'(FS));
  endtask

  task automatic wait_low;
    int n = 0;
    while (fft_load && n < FS + 8) begin
      tick(1);
      n++;
    end
    check("bus_returns_low", 32'(fft_load), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected finish before 2 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();
`ifdef SAMPLE_DECIM_EN
    send(16'h7FFF); send(16'h7FFF);
    exp_q.push_back({N'(0), 16'h7FFF});
    send(16'h8000); send(16'h7FFF);
    exp_q.push_back({N'(1), 16'hFFFF});
    for (int k = 2; k < FS; k++) begin
      exp_q.push_back({N'(k), W'(k)});
      send(W'(k));
      if (k == FS - 1) begin
        tick(4);
        check("dec_1023_no_frame", 32'(frame_pending), 32'd0);
        check("dec_1023_no_load", 32'(fft_load), 32'd0);
      end
      send(W'(k + 1));
    end
    wait_load("dec_latency", 2);
    burst("dec_burst_len", -1);
    check("dec_overrun", 32'(overrun), 32'd0);
    check("dec_queue_empty", 32'(exp_q.size()), 32'd0);
`else
    // Single frame, value = index, no fft_done.
    feed_frame(16'h0000);
    wait_load("t1_latency", 2);
    burst("t1_burst_len", -1);
    tick(20);
    check("t1_state_wait", 32'(state_dbg), 32'(ST_WAIT));
    check("t1_load_low", 32'(fft_load), 32'd0);
    check("t1_pending", 32'(frame_pending), 32'd0);
    check("t1_add_rd_hold", 32'(add_rd), 32'h1FF);
    check("t1_din_hold", 32'(din), 32'h1FF);
    check("t1_queue_empty", 32'(exp_q.size()), 32'd0);

    // Ping-pong: second frame waits for fft_done; fft_done during LOAD is ignored.
    do_reset();
    feed_frame(16'h1000);
    feed_frame(16'h2000);
    wait_low();
    check("t2_pending_one", 32'(frame_pending), 32'd1);
    check("t2_state_wait", 32'(state_dbg), 32'(ST_WAIT));
    tick(50);
    pulse_done();
    wait_load("t2_latency_after_done", 1);
    burst("t2_burst_len", 100);
    tick(5);
    check("t2_done_in_load_ignored", 32'(state_dbg), 32'(ST_WAIT));
    check("t2_pending_zero", 32'(frame_pending), 32'd0);
    check("t2_overrun", 32'(overrun), 32'd0);
    check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

    // Overrun: fill both banks, drop extras, sticky flag and clear priority.
    do_reset();
    feed_frame(16'h3000);
    feed_frame(16'h4000);
    wait_low();
    check("t3_pending_one", 32'(frame_pending), 32'd1);
    feed_frame(16'h5000);
    tick(2);
    check("t3_pending_two", 32'(frame_pending), 32'd2);
    check("t3_no_overrun_yet", 32'(overrun), 32'd0);
    send(16'h7E00); send(16'h7E01); send(16'h7E02);
    check("t3_overrun_set", 32'(overrun), 32'd1);
    check("t3_pending_still_two", 32'(frame_pending), 32'd2);
    tick(5);
    check("t3_overrun_sticky", 32'(overrun), 32'd1);
    s_data = 16'h7E03; s_valid = 1'b1; clr_overrun = 1'b1;
    tick(1);
    s_valid = 1'b0; clr_overrun = 1'b0;
    check("t3_set_beats_clear", 32'(overrun), 32'd1);
    clr_overrun = 1'b1;
    tick(1);
    clr_overrun = 1'b0;
    check("t3_overrun_cleared", 32'(overrun), 32'd0);
    pulse_done();
    wait_load("t3_latency_frame1", 1);
    burst("t3_burst1_len", -1);
    pulse_done();
    wait_load("t3_latency_frame2", 1);
    burst("t3_burst2_len", -1);
    tick(2);
    check("t3_pending_zero", 32'(frame_pending), 32'd0);
    check("t3_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a burst abandons it for good.
    do_reset();
    feed_frame(16'h6000);
    wait_load("t4_latency", 2);
    begin
      int g = 0;
      int hi = 0;
      while (add_rd != N'(200) && g < FS) begin
        tick(1);
        g++;
      end
      check("t4_reach_k200", 32'(add_rd), 32'd200);
      reset = 1'b0;
      exp_q.delete();
      #1;
      check("t4_load_drops", 32'(fft_load), 32'd0);
      check("t4_start_drops", 32'(fft_start), 32'd0);
      check("t4_pending_reset", 32'(frame_pending), 32'd0);
      check("t4_state_reset", 32'(state_dbg), 32'(ST_IDLE));
      tick(2);
      reset = 1'b1;
      repeat (700) begin
        tick(1);
        if (fft_load) hi++;
      end
      check("t4_no_burst_after_reset", 32'(hi), 32'd0);
    end
    feed_frame(16'h7000);
    wait_load("t4_fresh_latency", 2);
    burst("t4_fresh_burst_len", -1);
    check("t4_queue_empty", 32'(exp_q.size()), 32'd0);
`endif
    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
